mips_instr_encoder: RTL and testbench
=====================================

# mips_instr_encoder

Sequential MIPS instruction encoder and program-memory writer: the inverse of the opcode decoder in the control path. It accepts one instruction request per handshake, given as an instruction kind plus register, immediate, shift and funct fields. It packs each request into a 32-bit MIPS word and writes the word to consecutive instruction-memory addresses. It also expands the LI pseudo-instruction into an LUI/ORI pair. It sits between the test/boot loader and the instruction memory write port.

## Interface
- ADDR_WIDTH, 6, word-address width; capacity = 2**ADDR_WIDTH words
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous restart: count to 0, state IDLE
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_kind  in  4  0 R, 1 ADDI, 2 ORI, 3 LUI, 4 ANDI, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 J, 10 JAL, 11 LI, 12-15 illegal
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields
- in_funct  in  6  R-type funct
- in_imm  in  32  [15:0] for I-type, [25:0] for J/JAL target, [31:0] for LI
- wr_en  out  1  instruction-memory write strobe
- wr_addr  out  ADDR_WIDTH  word address of wr_data
- wr_data  out  32  encoded instruction
- word_count  out  ADDR_WIDTH+1  words written since reset/clear
- full  out  1  word_count == 2**ADDR_WIDTH
- error  out  1  one-cycle pulse: illegal kind, or LI with fewer than 2 free slots

## Operation
- Opcodes: R 0x00, ADDI 0x08, ORI 0x0d, LUI 0x0f, ANDI 0x0c, LW 0x23, SW 0x2b, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03.
- R format: {0x00, rs, rt, rd, shamt, funct}.
- I format: {op, rs, rt, imm[15:0]}. LUI forces rs = 0. The branch offset is taken raw; the encoder does no PC arithmetic.
- J format: {op, imm[25:0]}.
- LI expands to two words: LUI rt, imm[31:16], then ORI rt, rt, imm[15:0]. The ORI word uses rs = rt = in_rt.
- States:
  - IDLE: accepts requests.
  - LI2: emits the ORI word and refuses new requests.
- Transitions:
  - IDLE to LI2 on accepting an LI request that has room for both words.
  - LI2 to IDLE unconditionally on the next edge.
- in_ready = (state == IDLE) && !full && !clear. This is combinational from registered state.
- Handshake occurs when in_valid && in_ready. in_valid without in_ready has no effect, and the request fields need not be held by the encoder.
- Each emitted word: wr_addr = word_count before the write; word_count increments by 1.
- Illegal kind: the request is consumed, error pulses, no write, count unchanged.
- LI with exactly 1 free slot: the request is consumed, error pulses, no write.
- full: in_ready stays 0 until clear or reset. word_count never exceeds 2**ADDR_WIDTH and never wraps.
- clear has priority over everything:
  - aborts a pending LI second word;
  - no wr_en on the following edge;
  - word_count returns to 0.

## Timing
- Reset (asynchronous, active-low) drives all of the following to 0:
  - wr_en, wr_addr, wr_data;
  - word_count, full, error.
- Reset sets state to IDLE, so in_ready = 1 once reset is released.
- Latency: a handshake at edge N presents wr_en = 1 with the word during cycle N+1, one cycle wide. All write-port outputs are registered.
- Throughput:
  - one word per cycle for back-to-back non-LI requests;
  - LI occupies two cycles (LUI at N+1, ORI at N+2), with in_ready = 0 during cycle N+1.
- error is registered: high in cycle N+1 only.
- full rises in the same cycle as the wr_en of the last slot.
- When wr_en is low, wr_data and wr_addr hold their last values.
- Reset asserted during LI2: all outputs go to 0 immediately, and the ORI word is never emitted.

## Test plan
- ADDI rs=1 rt=2 imm=0x0005 after reset -> next cycle wr_en=1, wr_addr=0, wr_data=0x20220005; word_count=1.
- Back-to-back:
  - R rs=1 rt=2 rd=3 shamt=0 funct=0x20, then JAL imm=0x0100008;
  - required: wr_data 0x00221820 at address 0, then 0x0C100008 at address 1, on consecutive cycles.
- LI rt=8 imm=0x12345678 -> 0x3C081234 at address 0, then 0x35085678 at address 1. in_ready=0 for exactly one cycle; count=2.
- ADDR_WIDTH=2:
  - 3 ADDI requests, then LI -> error pulse, no write, count=3;
  - one more ADDI -> full=1, in_ready=0;
  - clear -> count=0, full=0, in_ready=1.
- in_kind=0xF -> error=1 for one cycle, wr_en=0, count unchanged. LW rs=29 rt=4 imm=0xFFFC -> 0x8FA4FFFC.
- Assert reset, and separately clear, during LI2 -> no ORI word; outputs 0 (reset) or count 0 (clear); next request is written at address 0.

Source files
------------

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_instr_encoder: packs instruction requests into MIPS words and writes |
// | them to consecutive instruction-memory addresses; expands LI to LUI/ORI.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mips_instr_encoder #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_kind,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [5:0]            in_funct,
  input  logic [31:0]           in_imm,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  full,
  output logic                  error
);

  localparam logic [ADDR_WIDTH+1:0] CAPACITY = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH+1:0] LI_WORDS = (ADDR_WIDTH+2)'(2);

  localparam logic [3:0] KIND_R    = 4'd0;
  localparam logic [3:0] KIND_ADDI = 4'd1;
  localparam logic [3:0] KIND_ORI  = 4'd2;
  localparam logic [3:0] KIND_LUI  = 4'd3;
  localparam logic [3:0] KIND_ANDI = 4'd4;
  localparam logic [3:0] KIND_LW   = 4'd5;
  localparam logic [3:0] KIND_SW   = 4'd6;
  localparam logic [3:0] KIND_BEQ  = 4'd7;
  localparam logic [3:0] KIND_BNE  = 4'd8;
  localparam logic [3:0] KIND_J    = 4'd9;
  localparam logic [3:0] KIND_JAL  = 4'd10;
  localparam logic [3:0] KIND_LI   = 4'd11;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LI2  = 1'b1
  } state_t;

  state_t                state;
  logic [4:0]            li_rt;
  logic [15:0]           li_lo;
  logic [31:0]           enc_word;
  logic                  enc_legal;
  logic                  enc_li;
  logic                  handshake;
  logic                  li_room;
  logic [ADDR_WIDTH:0]   count_inc;
  logic                  count_inc_full;

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  assign in_ready       = (state == ST_IDLE) && !full && !clear;
  assign handshake      = in_valid && in_ready;
  assign li_room        = ({1'b0, word_count} + LI_WORDS) <= CAPACITY;
  assign count_inc      = word_count + (ADDR_WIDTH+1)'(1);
  assign count_inc_full = ({1'b0, count_inc} == CAPACITY);

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    enc_li    = 1'b0;
    case (in_kind)
      KIND_R:    enc_word = {OP_R, in_rs, in_rt, in_rd, in_shamt, in_funct};
      KIND_ADDI: enc_word = i_word(OP_ADDI, in_rs, in_rt, in_imm[15:0]);
      KIND_ORI:  enc_word = i_word(OP_ORI,  in_rs, in_rt, in_imm[15:0]);
      KIND_LUI:  enc_word = i_word(OP_LUI,  5'd0,  in_rt, in_imm[15:0]);
      KIND_ANDI: enc_word = i_word(OP_ANDI, in_rs, in_rt, in_imm[15:0]);
      KIND_LW:   enc_word = i_word(OP_LW,   in_rs, in_rt, in_imm[15:0]);
      KIND_SW:   enc_word = i_word(OP_SW,   in_rs, in_rt, in_imm[15:0]);
      KIND_BEQ:  enc_word = i_word(OP_BEQ,  in_rs, in_rt, in_imm[15:0]);
      KIND_BNE:  enc_word = i_word(OP_BNE,  in_rs, in_rt, in_imm[15:0]);
      KIND_J:    enc_word = {OP_J,   in_imm[25:0]};
      KIND_JAL:  enc_word = {OP_JAL, in_imm[25:0]};
      KIND_LI: begin
        // First half of LI: upper immediate into rt
        enc_word = i_word(OP_LUI, 5'd0, in_rt, in_imm[31:16]);
        enc_li   = 1'b1;
      end
      default:   enc_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      li_rt      <= '0;
      li_lo      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
      full       <= 1'b0;
      error      <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      wr_en      <= 1'b0;
      word_count <= '0;
      full       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            if (!enc_legal || (enc_li && !li_room)) begin
              error <= 1'b1;
            end else begin
              wr_en      <= 1'b1;
              wr_addr    <= word_count[ADDR_WIDTH-1:0];
              wr_data    <= enc_word;
              word_count <= count_inc;
              full       <= count_inc_full;
              if (enc_li) begin
                state <= ST_LI2;
                li_rt <= in_rt;
                li_lo <= in_imm[15:0];
              end
            end
          end
        end
        ST_LI2: begin
          wr_en      <= 1'b1;
          wr_addr    <= word_count[ADDR_WIDTH-1:0];
          wr_data    <= i_word(OP_ORI, li_rt, li_rt, li_lo);
          word_count <= count_inc;
          full       <= count_inc_full;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// Directed testbench for mips_instr_encoder: a 64-word instance and a 4-word
// instance share clock, reset and request fields.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear, s_clear;
  logic        valid, s_valid;
  logic [3:0]  kind;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] imm;

  logic        in_ready, wr_en, full, error;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  word_count;

  logic        s_in_ready, s_wr_en, s_full, s_error;
  logic [1:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [2:0]  s_word_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(valid), .in_ready(in_ready), .in_kind(kind),
    .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(shamt),
    .in_funct(funct), .in_imm(imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_count(word_count), .full(full), .error(error)
  );

  mips_instr_encoder #(.ADDR_WIDTH(2)) dut_s (
    .clk(clk), .reset(reset), .clear(s_clear),
    .in_valid(s_valid), .in_ready(s_in_ready), .in_kind(kind),
    .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(shamt),
    .in_funct(funct), .in_imm(imm),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .word_count(s_word_count), .full(s_full), .error(s_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] k, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [4:0] sh, input logic [5:0] f,
                         input logic [31:0] im);
    kind = k; rs = a; rt = b; rd = d; shamt = sh; funct = f; imm = im;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, word_count, full, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h cnt=%0d full=%b err=%b, required all 0",
               wr_en, wr_addr, wr_data, word_count, full, error);
    end
    n_checks++;
    if ({s_wr_en, s_wr_addr, s_wr_data, s_word_count, s_full, s_error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_small: got nonzero outputs, required all 0");
    end
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_addi();
    set_req(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_0005);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'h2022_0005 || word_count !== 7'd1) begin
      n_fail++;
      $display("FAIL addi: got en=%b addr=%0d data=%h cnt=%0d, required en=1 addr=0 data=20220005 cnt=1",
               wr_en, wr_addr, wr_data, word_count);
    end
    tick();
    n_checks++;
    if (wr_en !== 1'b0 || wr_data !== 32'h2022_0005 || wr_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL addi_hold: got en=%b addr=%0d data=%h, required en=0 addr=0 data=20220005",
               wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'h0);
    valid = 1'b1;
    tick();
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'h0022_1820) begin
      n_fail++;
      $display("FAIL b2b_r: got en=%b addr=%0d data=%h, required en=1 addr=0 data=00221820",
               wr_en, wr_addr, wr_data);
    end
    set_req(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0010_0008);
    tick();
    valid = 1'b0;
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd1 || wr_data !== 32'h0C10_0008 || word_count !== 7'd2) begin
      n_fail++;
      $display("FAIL b2b_jal: got en=%b addr=%0d data=%h cnt=%0d, required en=1 addr=1 data=0c100008 cnt=2",
               wr_en, wr_addr, wr_data, word_count);
    end
  endtask

  task automatic test_li();
    do_clear();
    set_req(4'd11, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'h1234_5678);
    valid = 1'b1;
    tick();
    // A competing ADDI stays valid while the ORI half is pending
    set_req(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_0005);
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'h3C08_1234 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL li_lui: got en=%b addr=%0d data=%h rdy=%b, required en=1 addr=0 data=3c081234 rdy=0",
               wr_en, wr_addr, wr_data, in_ready);
    end
    tick();
    valid = 1'b0;
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd1 || wr_data !== 32'h3508_5678 || word_count !== 7'd2 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL li_ori: got en=%b addr=%0d data=%h cnt=%0d rdy=%b, required en=1 addr=1 data=35085678 cnt=2 rdy=1",
               wr_en, wr_addr, wr_data, word_count, in_ready);
    end
    tick();
    n_checks++;
    if (wr_en !== 1'b0 || word_count !== 7'd2) begin
      n_fail++;
      $display("FAIL li_refused: got en=%b cnt=%0d, required en=0 cnt=2", wr_en, word_count);
    end
  endtask

  task automatic test_illegal_and_lw();
    do_clear();
    set_req(4'hF, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0, 32'h0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n_checks++;
    if (error !== 1'b1 || wr_en !== 1'b0 || word_count !== 7'd0) begin
      n_fail++;
      $display("FAIL illegal: got err=%b en=%b cnt=%0d, required err=1 en=0 cnt=0", error, wr_en, word_count);
    end
    tick();
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse: got err=%b required 0", error);
    end
    set_req(4'd5, 5'd29, 5'd4, 5'd0, 5'd0, 6'd0, 32'h0000_FFFC);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'h8FA4_FFFC || word_count !== 7'd1) begin
      n_fail++;
      $display("FAIL lw: got en=%b addr=%0d data=%h cnt=%0d, required en=1 addr=0 data=8fa4fffc cnt=1",
               wr_en, wr_addr, wr_data, word_count);
    end
  endtask

  task automatic test_small_full();
    set_req(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_0005);
    s_valid = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (s_word_count !== 3'd3 || s_wr_addr !== 2'd2 || s_full !== 1'b0) begin
      n_fail++;
      $display("FAIL small_three: got cnt=%0d addr=%0d full=%b, required cnt=3 addr=2 full=0",
               s_word_count, s_wr_addr, s_full);
    end
    set_req(4'd11, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'h1234_5678);
    tick();
    n_checks++;
    if (s_error !== 1'b1 || s_wr_en !== 1'b0 || s_word_count !== 3'd3) begin
      n_fail++;
      $display("FAIL small_li_room: got err=%b en=%b cnt=%0d, required err=1 en=0 cnt=3",
               s_error, s_wr_en, s_word_count);
    end
    set_req(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_0005);
    tick();
    s_valid = 1'b0;
    #1;
    n_checks++;
    if (s_full !== 1'b1 || s_in_ready !== 1'b0 || s_word_count !== 3'd4 || s_wr_en !== 1'b1 || s_wr_addr !== 2'd3) begin
      n_fail++;
      $display("FAIL small_full: got full=%b rdy=%b cnt=%0d en=%b addr=%0d, required full=1 rdy=0 cnt=4 en=1 addr=3",
               s_full, s_in_ready, s_word_count, s_wr_en, s_wr_addr);
    end
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    n_checks++;
    if (s_word_count !== 3'd4 || s_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL small_no_wrap: got cnt=%0d en=%b, required cnt=4 en=0", s_word_count, s_wr_en);
    end
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    #1;
    n_checks++;
    if (s_word_count !== 3'd0 || s_full !== 1'b0 || s_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL small_clear: got cnt=%0d full=%b rdy=%b, required cnt=0 full=0 rdy=1",
               s_word_count, s_full, s_in_ready);
    end
  endtask

  task automatic test_clear_li2();
    do_clear();
    set_req(4'd11, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'h1234_5678);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (wr_en !== 1'b0 || word_count !== 7'd0) begin
      n_fail++;
      $display("FAIL clear_li2: got en=%b cnt=%0d, required en=0 cnt=0", wr_en, word_count);
    end
    tick();
    n_checks++;
    if (wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_li2_no_ori: got en=%b required 0", wr_en);
    end
    set_req(4'd2, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 32'h0000_00FF);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'h3464_00FF || word_count !== 7'd1) begin
      n_fail++;
      $display("FAIL clear_li2_next: got en=%b addr=%0d data=%h cnt=%0d, required en=1 addr=0 data=346400ff cnt=1",
               wr_en, wr_addr, wr_data, word_count);
    end
  endtask

  task automatic test_reset_li2();
    do_clear();
    set_req(4'd11, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'h1234_5678);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, word_count, full, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_li2_async: got en=%b addr=%h data=%h cnt=%0d, required all 0",
               wr_en, wr_addr, wr_data, word_count);
    end
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (wr_en !== 1'b0 || word_count !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_li2_no_ori: got en=%b cnt=%0d, required en=0 cnt=0", wr_en, word_count);
    end
    set_req(4'd6, 5'd29, 5'd31, 5'd0, 5'd0, 6'd0, 32'h0000_0010);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'hAFBF_0010 || word_count !== 7'd1) begin
      n_fail++;
      $display("FAIL reset_li2_next: got en=%b addr=%0d data=%h cnt=%0d, required en=1 addr=0 data=afbf0010 cnt=1",
               wr_en, wr_addr, wr_data, word_count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; clear = 1'b0; s_clear = 1'b0; valid = 1'b0; s_valid = 1'b0;
    set_req(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0);
    test_reset();
    test_addi();
    test_back_to_back();
    test_li();
    test_illegal_and_lw();
    test_small_full();
    test_clear_li2();
    test_reset_li2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
